// File: rtl/req_priority_arbiter8.sv
// Eight-requester arbiter: highest-index (or rotating) priority, registered one-hot grant held
// until release or hold timeout, with a mandatory dead cycle between owners. Optional rotation: ARB_ROUND_ROBIN_EN.
module req_priority_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       expire
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_gnt;
    logic [7:0]       w_gnt_nxt;
    logic [2:0]       r_gnt_id;
    logic [2:0]       w_gnt_id_nxt;
    logic             r_gnt_valid;
    logic             w_gnt_valid_nxt;
    logic             r_expire;
    logic             w_expire_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_mask_valid;
    logic             w_mask_valid_nxt;
    logic [2:0]       r_mask_id;
    logic [2:0]       w_mask_id_nxt;
    logic [7:0]       w_mask_vec;
    logic [7:0]       w_elig;
    logic [2:0]       w_win;
    logic             w_timeout;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
`endif

    // Eligible requests: the timed-out index is skipped unless it is the only one asking.
    always_comb begin
        w_mask_vec = r_mask_valid ? (8'd1 << r_mask_id) : 8'd0;
        w_elig     = ((req & ~w_mask_vec) != 8'd0) ? (req & ~w_mask_vec) : req;
        w_timeout  = (MAX_HOLD != 32'd0) && (r_hold_cnt == HOLD_LAST);
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Rotating scan ptr, ptr-1, ...; the last hit in this loop order is the closest to ptr.
    always_comb begin
        w_win = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_win = w_elig[r_ptr - 3'(k)] ? (r_ptr - 3'(k)) : w_win;
        end
    end
`else
    // Fixed priority encoder: the highest set index wins.
    always_comb begin
        w_win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_win = w_elig[i] ? 3'(i) : w_win;
        end
    end
`endif

    // Next-state and next-output logic; the expire pulse defaults low so it lasts one cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_gnt_id_nxt     = r_gnt_id;
        w_gnt_valid_nxt  = r_gnt_valid;
        w_expire_nxt     = 1'b0;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_mask_valid_nxt = r_mask_valid;
        w_mask_id_nxt    = r_mask_id;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt        = r_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req != 8'd0) begin
                    w_state_nxt      = ST_BUSY;
                    w_gnt_nxt        = 8'd1 << w_win;
                    w_gnt_id_nxt     = w_win;
                    w_gnt_valid_nxt  = 1'b1;
                    w_hold_cnt_nxt   = {CNT_W{1'b0}};
                    w_mask_valid_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr_nxt        = w_win - 3'd1;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!req[r_gnt_id]) begin
                    w_state_nxt     = ST_GAP;
                    w_gnt_nxt       = 8'd0;
                    w_gnt_id_nxt    = 3'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_cnt_nxt  = {CNT_W{1'b0}};
                end else if (w_timeout) begin
                    w_state_nxt      = ST_GAP;
                    w_gnt_nxt        = 8'd0;
                    w_gnt_id_nxt     = 3'd0;
                    w_gnt_valid_nxt  = 1'b0;
                    w_hold_cnt_nxt   = {CNT_W{1'b0}};
                    w_expire_nxt     = 1'b1;
                    w_mask_valid_nxt = 1'b1;
                    w_mask_id_nxt    = r_gnt_id;
                end else begin
                    w_hold_cnt_nxt = (MAX_HOLD != 32'd0) ? (r_hold_cnt + CNT_ONE) : r_hold_cnt;
                end
            end
            ST_GAP: begin
                w_state_nxt     = ST_IDLE;
                w_gnt_nxt       = 8'd0;
                w_gnt_id_nxt    = 3'd0;
                w_gnt_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_gnt_nxt       = 8'd0;
                w_gnt_id_nxt    = 3'd0;
                w_gnt_valid_nxt = 1'b0;
                w_hold_cnt_nxt  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 8'd0;
            r_gnt_id     <= 3'd0;
            r_gnt_valid  <= 1'b0;
            r_expire     <= 1'b0;
            r_hold_cnt   <= {CNT_W{1'b0}};
            r_mask_valid <= 1'b0;
            r_mask_id    <= 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr        <= 3'd7;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_gnt_id     <= w_gnt_id_nxt;
            r_gnt_valid  <= w_gnt_valid_nxt;
            r_expire     <= w_expire_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_mask_valid <= w_mask_valid_nxt;
            r_mask_id    <= w_mask_id_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr        <= w_ptr_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign expire    = r_expire;

endmodule
